// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus bundle.
// Groups the three handshakes around the fetch unit:
//   pc side      : pc, pc_valid -> pc_ready, plus flush (jump taken)
//   memory side  : mem_req, mem_addr -> mem_ack, mem_rdata
//   decoder side : instr, instr_addr, instr_valid -> instr_ready
// Modports:
//   slave  : the fetch unit itself
//   master : everything around it (program counter, instruction memory,
//            decoder), as seen by an environment or testbench
interface instruction_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              pc_ready;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_valid;
  logic              instr_ready;

  modport slave (
    input  pc, pc_valid, flush, mem_ack, mem_rdata, instr_ready,
    output pc_ready, mem_req, mem_addr, instr, instr_addr, instr_valid
  );

  modport master (
    output pc, pc_valid, flush, mem_ack, mem_rdata, instr_ready,
    input  pc_ready, mem_req, mem_addr, instr, instr_addr, instr_valid
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit.
// Accepts one fetch address at a time from the program counter, issues a
// single outstanding read to instruction memory, and queues returned words
// with their addresses in a 2-entry FIFO for the decoder. A flush (taken
// jump) empties the FIFO and, if a read is still in flight, drains it so
// the stale word is dropped.
// Ports:
//   clk   : clock, all state changes on its rising edge
//   reset : asynchronous, active-high
//   bus   : instruction_fetch_if.slave (pc / memory / decoder handshakes)
module instruction_fetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  instruction_fetch_if.slave bus
);

  // Encoding chosen so that bit 0 is set exactly in the states with a read
  // outstanding; mem_req is then a direct flop output.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    DRAIN = 2'b11
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] mem_addr_q;

  logic [ADDR_W-1:0] fifo_addr [2];
  logic [DATA_W-1:0] fifo_data [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic              fifo_full;
  logic              fifo_vld;
  logic              pc_ready_c;
  logic              accept;
  logic              push;
  logic              pop;

  // FSM: next state and handshake decode
  always_comb begin
    state_nxt  = state;
    fifo_full  = (count == 2'd2);
    fifo_vld   = (count != 2'd0);
    pc_ready_c = (state == IDLE) && !fifo_full && !bus.flush;
    accept     = bus.pc_valid && pc_ready_c;
    // A word returning together with a flush belongs to the abandoned path.
    push       = (state == REQ) && bus.mem_ack && !bus.flush;
    // Flush takes precedence: a simultaneous pop is absorbed.
    pop        = fifo_vld && bus.instr_ready && !bus.flush;

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          state_nxt = IDLE;
        end else if (bus.flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Memory request address: loaded on acceptance, held through REQ/DRAIN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_q <= '0;
    end else if (accept) begin
      mem_addr_q <= bus.pc;
    end
  end

  // FIFO control: pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (bus.flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: data only, no reset; the output gating below keeps the
  // decoder-facing bus at zero whenever nothing valid is held.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mem_addr_q;
      fifo_data[wr_ptr] <= bus.mem_rdata;
    end
  end

  assign bus.pc_ready    = pc_ready_c;
  assign bus.mem_req     = state[0];
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = fifo_vld;
  assign bus.instr       = fifo_vld ? fifo_data[rd_ptr] : '0;
  assign bus.instr_addr  = fifo_vld ? fifo_addr[rd_ptr] : '0;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_W, default 16, width of the program-counter and memory address.
REQ-002 Parameter DATA_W, default 16, width of an instruction word.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc  input  ADDR_W  address to fetch, driven by the program counter.
REQ-006 pc_valid  input  1  pc holds an address to fetch.
REQ-007 pc_ready  output  1  block accepts pc this cycle; combinational.
REQ-008 flush  input  1  discard all buffered and in-flight fetches (jump taken).
REQ-009 mem_req  output  1  registered read request to instruction memory.
REQ-010 mem_addr  output  ADDR_W  registered read address, valid while mem_req is high.
REQ-011 mem_ack  input  1  memory has mem_rdata valid for the current request.
REQ-012 mem_rdata  input  DATA_W  instruction word returned by memory.
REQ-013 instr  output  DATA_W  head-of-queue instruction to the decoder.
REQ-014 instr_addr  output  ADDR_W  address the head instruction was fetched from.
REQ-015 instr_valid  output  1  instr and instr_addr are valid.
REQ-016 instr_ready  input  1  decoder consumes the head entry this cycle.

Function
REQ-017 The block SHALL contain a 2-entry FIFO of {instr_addr, instr} pairs and an FSM with states IDLE, REQ and DRAIN.
REQ-018 pc_ready SHALL be 1 only when state==IDLE, FIFO count<2 and flush==0.
REQ-019 On pc_valid&&pc_ready at an edge, mem_addr SHALL load pc, mem_req SHALL go 1 and the state SHALL go REQ.
REQ-020 In REQ, mem_req and mem_addr SHALL hold stable until mem_ack is sampled 1; at that edge mem_rdata and mem_addr are pushed to the FIFO tail, mem_req goes 0 and the state returns to IDLE.
REQ-021 At most one memory request SHALL be outstanding; mem_ack sampled in IDLE SHALL be ignored.
REQ-022 Minimum latency: pc accepted at edge N, mem_ack high in the following cycle, instr_valid=1 after edge N+1.
REQ-023 instr_valid SHALL equal FIFO-not-empty; instr and instr_addr SHALL be the head entry and SHALL hold stable while instr_valid&&!instr_ready.
REQ-024 The head SHALL be popped on instr_valid&&instr_ready; a simultaneous push and pop SHALL leave the count unchanged with correct ordering.
REQ-025 flush sampled 1 SHALL empty the FIFO at that edge; a pop in the same cycle is absorbed by the flush.
REQ-026 If flush is sampled 1 in REQ without mem_ack, the state SHALL go DRAIN with mem_req and mem_addr held; in DRAIN, mem_ack SHALL return to IDLE and discard mem_rdata.
REQ-027 If flush and mem_ack are sampled 1 together in REQ, the returned word SHALL be discarded and the state SHALL go IDLE.
REQ-028 flush in IDLE SHALL only empty the FIFO; flush in DRAIN SHALL have no further effect.
REQ-029 Addresses SHALL pass through unmodified; 0 and 2^ADDR_W-1 SHALL be legal fetch addresses.

Reset
REQ-030 reset=1 SHALL asynchronously force state IDLE, FIFO empty, and mem_req=0, mem_addr=0, instr=0, instr_addr=0, instr_valid=0.
REQ-031 Reset during REQ or DRAIN SHALL abandon the request; a later mem_ack in IDLE SHALL be ignored.
REQ-032 After reset is released, the first pc handshake SHALL be possible at the first rising edge.

Verification
REQ-033 Basic fetch: pc=0x0003, pc_valid, memory acks next cycle with 0xABCD -> instr=0xABCD, instr_addr=0x0003, instr_valid=1.
REQ-034 Backpressure: instr_ready=0, fetch 0x0010 then 0x0011 -> pc_ready=0 after two entries are held; pops return the entries in order with data unchanged.
REQ-035 Slow memory: mem_ack delayed 3 cycles -> mem_req=1 and mem_addr constant for the whole wait; exactly one push.
REQ-036 Flush mid-request: flush in REQ, ack 2 cycles later with 0x1234 -> instr_valid stays 0; pc_ready=0 until the ack, then 1.
REQ-037 Boundary address: fetch 0xFFFF then 0x0000 -> instr_addr=0xFFFF, then 0x0000.
REQ-038 Reset mid-request: assert reset in REQ without a clock edge -> mem_req=0 and instr_valid=0 immediately; a stray mem_ack afterwards produces no entry.
